// File: rtl/julia_pkg.sv
// Shared types and widths for the Julia frame sequencer.
// Frame walk states plus datapath word widths.
package julia_pkg;

  localparam int COUNT_W = 13;
  localparam int COLOR_W = 8;
  localparam int FW      = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/julia_frame_sequencer_walker.sv
// Pixel walker: x/y raster counters, linear frame buffer address
// and a flag for the final pixel of the frame.
module julia_pixel_walker #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [X_W-1:0]    x_o,
  output logic [Y_W-1:0]    y_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              x_end;

  assign x_end = (x_q == X_W'(H_RES - 1));

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clr_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (adv_i) begin
      // running address avoids a y*H_RES multiplier
      addr_d = addr_q + 1'b1;
      if (x_end) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;
  assign last_o = x_end && (y_q == Y_W'(V_RES - 1));

endmodule

// File: rtl/julia_frame_sequencer.sv
// Julia frame sequencer: walks the frame, feeds the iteration datapath
// and writes colours out. JULIA_SEQ_STALL_CNT_EN adds stall_cycles.
module julia_frame_sequencer
  import julia_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int ADDR_W      = 19,
  parameter int MAX_COUNT   = 8191,
  parameter int ACLR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [FW-1:0]        rCin,
  input  logic [FW-1:0]        iCin,
  output logic                 busy,
  output logic                 done,
  output logic [X_W-1:0]       x_addr,
  output logic [Y_W-1:0]       y_addr,
  input  logic [FW-1:0]        rz_rom,
  input  logic [FW-1:0]        iz_rom,
  output logic [FW-1:0]        rZout,
  output logic [FW-1:0]        iZout,
  output logic [FW-1:0]        rCout,
  output logic [FW-1:0]        iCout,
  output logic [COUNT_W-1:0]   count,
  output logic                 aclr,
  input  logic [COLOR_W-1:0]   red_in,
  input  logic [COLOR_W-1:0]   blue_in,
  output logic [ADDR_W-1:0]    fb_addr,
  output logic [2*COLOR_W-1:0] fb_data,
  output logic                 fb_we,
  input  logic                 fb_ready
`ifdef JULIA_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int ACW = (ACLR_CYCLES > 1) ? $clog2(ACLR_CYCLES) : 1;

  state_e                 state_q;
  logic                   busy_q, done_q, aclr_q, we_q;
  logic [ACW-1:0]         acnt_q;
  logic [COUNT_W-1:0]     cnt_q;
  logic [FW-1:0]          rc_q, ic_q, rz_q, iz_q;
  logic [2*COLOR_W-1:0]   fbd_q;
  logic                   walk_clr, walk_adv, last_px;
`ifdef JULIA_SEQ_STALL_CNT_EN
  logic [31:0]            stall_q;
`endif

  assign walk_clr = (state_q == IDLE) && start;
  assign walk_adv = (state_q == WRITE) && fb_ready && !last_px;

  julia_pixel_walker #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_walker (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (walk_clr),
    .adv_i  (walk_adv),
    .x_o    (x_addr),
    .y_o    (y_addr),
    .addr_o (fb_addr),
    .last_o (last_px)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aclr_q  <= 1'b0;
      we_q    <= 1'b0;
      acnt_q  <= '0;
      cnt_q   <= '0;
      rc_q    <= '0;
      ic_q    <= '0;
      rz_q    <= '0;
      iz_q    <= '0;
      fbd_q   <= '0;
`ifdef JULIA_SEQ_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            rc_q    <= rCin;
            ic_q    <= iCin;
            busy_q  <= 1'b1;
            aclr_q  <= 1'b1;
            acnt_q  <= '0;
            state_q <= CLEAR;
`ifdef JULIA_SEQ_STALL_CNT_EN
            stall_q <= '0;
`endif
          end
        end
        CLEAR: begin
          // ROM data for the new x/y is valid by the last clear cycle
          if (acnt_q == ACW'(ACLR_CYCLES - 1)) begin
            rz_q    <= rz_rom;
            iz_q    <= iz_rom;
            aclr_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            acnt_q <= acnt_q + 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == COUNT_W'(MAX_COUNT)) begin
            state_q <= SETTLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          fbd_q   <= {red_in, blue_in};
          we_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= WRITE;
        end
        WRITE: begin
          if (fb_ready) begin
            we_q <= 1'b0;
            if (last_px) begin
              state_q <= DONE;
            end else begin
              aclr_q  <= 1'b1;
              acnt_q  <= '0;
              state_q <= CLEAR;
            end
          end
`ifdef JULIA_SEQ_STALL_CNT_EN
          else if (stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
          end
`endif
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign aclr    = aclr_q;
  assign count   = cnt_q;
  assign rCout   = rc_q;
  assign iCout   = ic_q;
  assign rZout   = rz_q;
  assign iZout   = iz_q;
  assign fb_data = fbd_q;
  assign fb_we   = we_q;
`ifdef JULIA_SEQ_STALL_CNT_EN
  assign stall_cycles = stall_q;
`endif

endmodule
